// File: rtl/pc_branch_unit_pkg.sv
// Shared MIPS fetch constants: reset PC, sequencer state encodings, target field widths.
// Imported by the PC sequencer and its branch-offset adder.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          ADDR_W_DEF   = 32;
    localparam int          IMM_W        = 16;
    localparam int          JIDX_W       = 26;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_SLOT = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

    // Word offset -> byte offset: shift left 2, then sign-extend from bit 17.
    function automatic logic [31:0] br_offset(input logic [IMM_W-1:0] imm);
        return {{14{imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Redirect/control inputs and PC/status outputs of the fetch PC sequencer.
// master = fetch/decode side driving redirects, slave = the sequencer.
interface pc_branch_unit_if;
    import mips_pkg::*;

    logic              stall;
    logic              halt;
    logic              br_take;
    logic [IMM_W-1:0]  br_imm16;
    logic              jump;
    logic [JIDX_W-1:0] j_index;
    logic              jr;
    logic [31:0]       jr_addr;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic [31:0]       br_target;
    logic              flush;
    logic              misalign_err;
    logic              slot_err;
    logic [1:0]        state;

    modport master (
        output stall, halt, br_take, br_imm16, jump, j_index, jr, jr_addr,
        input  pc, pc_plus4, br_target, flush, misalign_err, slot_err, state
    );

    modport slave (
        input  stall, halt, br_take, br_imm16, jump, j_index, jr, jr_addr,
        output pc, pc_plus4, br_target, flush, misalign_err, slot_err, state
    );

endinterface

// File: rtl/pc_branch_unit_branch_ext16.sv
// Branch target adder: pc+4 plus the shifted, sign-extended 16-bit word offset.
// Latency: combinational. Backpressure: none.
module branch_ext16
    import mips_pkg::*;
(
    input  logic [31:0]      pc_plus4_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic [31:0]      target_o
);

    // Modulo-2^32 add; wrap past 32'hFFFF_FFFC is intentionally silent.
    assign target_o = pc_plus4_i + br_offset(imm_i);

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC sequencer: sequential fetch, beq/bne, j/jal, jr redirects, stall, halt.
// Latency: redirect visible on pc the next edge (or after one delay slot with DELAY_SLOT_EN).
// Backpressure: stall holds pc/state/pending target; halt freezes until rst.
module pc_branch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF
)(
    input  logic         clk,
    input  logic         rst,
    pc_branch_unit_if.slave bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    pc_state_e         state_q, state_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] redir_target;
    logic              redirect;

    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {pc_plus4[31:28], bus.j_index, 2'b00};
    assign jr_target   = {bus.jr_addr[31:2], 2'b00};
    assign redirect    = bus.jr | bus.jump | bus.br_take;

    branch_ext16 u_ext (
        .pc_plus4_i (pc_plus4),
        .imm_i      (bus.br_imm16),
        .target_o   (br_target)
    );

    always_comb begin
        redir_target = br_target;
        if (bus.jr)
            redir_target = jr_target;
        else if (bus.jump)
            redir_target = jump_target;
    end

`ifdef DELAY_SLOT_EN
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              slot_err_q, slot_err_d;
`endif

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        flush_d    = 1'b0;
        misalign_d = misalign_q;
`ifdef DELAY_SLOT_EN
        pend_d     = pend_q;
        slot_err_d = slot_err_q;
        if (state_q == ST_SLOT && redirect)
            slot_err_d = 1'b1;
`endif
        // Error flags track the inputs even while stalled.
        if (bus.jr && bus.jr_addr[1:0] != 2'b00)
            misalign_d = 1'b1;

        if (state_q == ST_HALT) begin
            flush_d = flush_q;
        end else if (bus.halt) begin
            state_d = ST_HALT;
        end else if (!bus.stall) begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
`ifdef DELAY_SLOT_EN
                        pend_d  = redir_target;
                        pc_d    = pc_plus4;
                        state_d = ST_SLOT;
`else
                        pc_d    = redir_target;
                        flush_d = 1'b1;
`endif
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
`ifdef DELAY_SLOT_EN
                ST_SLOT: begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end
`endif
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= ST_RUN;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
`ifdef DELAY_SLOT_EN
            pend_q     <= '0;
            slot_err_q <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
`ifdef DELAY_SLOT_EN
            pend_q     <= pend_d;
            slot_err_q <= slot_err_d;
`endif
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.br_target    = br_target;
    assign bus.flush        = flush_q;
    assign bus.misalign_err = misalign_q;
    assign bus.state        = state_q;
`ifdef DELAY_SLOT_EN
    assign bus.slot_err     = slot_err_q;
`else
    assign bus.slot_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; expectations follow DELAY_SLOT_EN when defined.
module tb_pc_branch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_branch_unit_if bus();

    pc_branch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall    = 1'b0;
        bus.halt     = 1'b0;
        bus.br_take  = 1'b0;
        bus.br_imm16 = 16'h0000;
        bus.jump     = 1'b0;
        bus.j_index  = 26'h0;
        bus.jr       = 1'b0;
        bus.jr_addr  = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] frozen;
        idle_inputs();
        do_reset();
        check("rst_pc", bus.pc, 32'h0000_3000);
        check("rst_state", {30'd0, bus.state}, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        check("rst_slot_err", {31'd0, bus.slot_err}, 32'd0);
        step(); check("seq1", bus.pc, 32'h0000_3004);
        step(); check("seq2", bus.pc, 32'h0000_3008);
        step(); check("seq3", bus.pc, 32'h0000_300C);
        check("pc_plus4", bus.pc_plus4, 32'h0000_3010);

        // Backward branch from 3010
        step(); check("seq4", bus.pc, 32'h0000_3010);
        bus.br_take = 1'b1; bus.br_imm16 = 16'hFFFC;
        #1 check("bwd_target", bus.br_target, 32'h0000_3004);
        step(); idle_inputs();
`ifdef DELAY_SLOT_EN
        check("bwd_slot_pc", bus.pc, 32'h0000_3014);
        check("bwd_slot_state", {30'd0, bus.state}, 32'd1);
        check("bwd_slot_flush", {31'd0, bus.flush}, 32'd0);
        step();
        check("bwd_pc", bus.pc, 32'h0000_3004);
        check("bwd_state", {30'd0, bus.state}, 32'd0);
`else
        check("bwd_pc", bus.pc, 32'h0000_3004);
        check("bwd_flush", {31'd0, bus.flush}, 32'd1);
        step();
        check("bwd_flush_end", {31'd0, bus.flush}, 32'd0);
        check("bwd_after", bus.pc, 32'h0000_3008);
`endif

        // Forward branch from 3000
        do_reset();
        bus.br_take = 1'b1; bus.br_imm16 = 16'h0003;
        #1 check("fwd_target", bus.br_target, 32'h0000_3010);
        step(); idle_inputs();
`ifdef DELAY_SLOT_EN
        check("fwd_slot_pc", bus.pc, 32'h0000_3004);
        step();
`endif
        check("fwd_pc", bus.pc, 32'h0000_3010);

        // Jump from 3000
        do_reset();
        bus.jump = 1'b1; bus.j_index = 26'h0000C10;
        step(); idle_inputs();
`ifdef DELAY_SLOT_EN
        check("jmp_slot_pc", bus.pc, 32'h0000_3004);
        step();
`endif
        check("jmp_pc", bus.pc, 32'h0000_3040);

        // Misaligned jr from 3040
        bus.jr = 1'b1; bus.jr_addr = 32'h0000_3022;
        step(); idle_inputs();
        check("jr_misalign", {31'd0, bus.misalign_err}, 32'd1);
`ifdef DELAY_SLOT_EN
        check("jr_slot_pc", bus.pc, 32'h0000_3044);
        step();
`endif
        check("jr_pc", bus.pc, 32'h0000_3020);
        step(); step();
        check("jr_misalign_sticky", {31'd0, bus.misalign_err}, 32'd1);
        check("jr_seq", bus.pc, 32'h0000_3028);

        // Priority: jump beats br_take, jr beats both
        do_reset();
        check("rst_clears_misalign", {31'd0, bus.misalign_err}, 32'd0);
        bus.jump = 1'b1; bus.j_index = 26'h0000C10;
        bus.br_take = 1'b1; bus.br_imm16 = 16'h0003;
        bus.jr = 1'b1; bus.jr_addr = 32'h0000_5000;
        step(); idle_inputs();
`ifdef DELAY_SLOT_EN
        step();
`endif
        check("prio_jr", bus.pc, 32'h0000_5000);
        check("prio_aligned", {31'd0, bus.misalign_err}, 32'd0);
        do_reset();
        bus.jump = 1'b1; bus.j_index = 26'h0000C10;
        bus.br_take = 1'b1; bus.br_imm16 = 16'h0003;
        step(); idle_inputs();
`ifdef DELAY_SLOT_EN
        step();
`endif
        check("prio_jump", bus.pc, 32'h0000_3040);

        // Stall
        do_reset();
`ifdef DELAY_SLOT_EN
        bus.br_take = 1'b1; bus.br_imm16 = 16'h0003;
        step(); idle_inputs();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", bus.pc, 32'h0000_3004);
            check("stall_state", {30'd0, bus.state}, 32'd1);
        end
        bus.stall = 1'b0;
        step();
        check("stall_release_pc", bus.pc, 32'h0000_3010);
        check("stall_release_state", {30'd0, bus.state}, 32'd0);
`else
        bus.stall = 1'b1; bus.br_take = 1'b1; bus.br_imm16 = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", bus.pc, 32'h0000_3000);
            check("stall_flush", {31'd0, bus.flush}, 32'd0);
        end
        bus.stall = 1'b0;
        step(); idle_inputs();
        check("stall_release_pc", bus.pc, 32'h0000_3010);
        check("stall_release_flush", {31'd0, bus.flush}, 32'd1);
`endif

        // Slot conflict / slot_err
        do_reset();
        bus.br_take = 1'b1; bus.br_imm16 = 16'h0003;
        step(); idle_inputs();
        bus.jump = 1'b1; bus.j_index = 26'h0000C10;
        step(); idle_inputs();
`ifdef DELAY_SLOT_EN
        check("slot_conflict_pc", bus.pc, 32'h0000_3010);
        check("slot_err_set", {31'd0, bus.slot_err}, 32'd1);
        step();
        check("slot_err_sticky", {31'd0, bus.slot_err}, 32'd1);
`else
        check("no_slot_jump_pc", bus.pc, 32'h0000_3040);
        check("slot_err_zero", {31'd0, bus.slot_err}, 32'd0);
`endif

        // One-instruction loop: imm = -1 targets the branch itself
        do_reset();
        bus.br_take = 1'b1; bus.br_imm16 = 16'hFFFF;
        #1 check("loop_target", bus.br_target, 32'h0000_3000);
        step(); idle_inputs();
`ifdef DELAY_SLOT_EN
        step();
`endif
        check("loop_pc", bus.pc, 32'h0000_3000);

        // Halt with stall: halt wins, pc frozen until rst
        do_reset();
        step(); step();
        frozen = bus.pc;
        check("pre_halt_pc", frozen, 32'h0000_3008);
        bus.halt = 1'b1; bus.stall = 1'b1;
        step(); idle_inputs();
        check("halt_state", {30'd0, bus.state}, 32'd2);
        bus.br_take = 1'b1; bus.br_imm16 = 16'h0010;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_pc", bus.pc, 32'h0000_3008);
        end
        check("halt_state_hold", {30'd0, bus.state}, 32'd2);
        do_reset();
        check("halt_rst_pc", bus.pc, 32'h0000_3000);
        check("halt_rst_state", {30'd0, bus.state}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Fetch-side program-counter sequencer for the MIPS core.
- Consumes the raw 16-bit beq/bne immediate, shifts it left 2, sign-extends it to 32 bits and adds it to PC+4 to form the branch target.
- Also applies j/jal and jr redirects, stalls and halt, and tracks an optional branch delay slot with a small state machine.
- Drives instruction-memory address and PC+4 to the link/writeback path.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and state this cycle
- halt  input  1  enter HALTED; PC frozen until rst
- br_take  input  1  branch at current PC resolved taken
- br_imm16  input  16  raw branch immediate (word offset)
- jump  input  1  j/jal at current PC
- j_index  input  26  jump instr_index
- jr  input  1  jr/jalr at current PC
- jr_addr  input  32  register target
- pc  output  32  current fetch address (registered)
- pc_plus4  output  32  pc + 4 (combinational)
- br_target  output  32  pc + 4 + {{14{br_imm16[15]}}, br_imm16, 2'b00} (combinational)
- flush  output  1  squash fetched instruction (registered, 1-cycle pulse)
- misalign_err  output  1  sticky: jr_addr[1:0] != 0 seen
- slot_err  output  1  sticky: control transfer requested in delay slot
- state  output  2  00 RUN, 01 SLOT, 10 HALTED

Behaviour:
- Reset (rst=1 at clk edge, any state):
  - pc=RESET_PC, state=RUN, flush=0, misalign_err=0, slot_err=0, pending target cleared.
- Sign extension of br_imm16:
  - Upper 14 bits all copy br_imm16[15]; shifted value occupies bits [17:0] of the offset.
  - Addition is 32-bit modulo 2^32; wrap-around at 32'hFFFF_FFFC is silent.
- Jump target: {pc_plus4[31:28], j_index, 2'b00}.
- jr target: {jr_addr[31:2], 2'b00}; misalign_err set if jr_addr[1:0] != 0.
- Per-edge priority: rst > halt > stall > jr > jump > br_take > sequential.
- Redirect target: the highest-priority active source among jr, jump and br_take.
- RUN:
  - With no redirect, pc <= pc_plus4.
  - With a redirect, behaviour depends on the delay-slot option.
- SLOT (delay-slot option only):
  - pc <= pending target, state <= RUN.
  - Any jr/jump/br_take this cycle is ignored and slot_err set.
- HALTED: pc, flush and pending target held. Only rst exits.
- stall=1: pc, state, pending target held; flush forced 0 that cycle. Error flags still update from the inputs.
- halt and stall asserted together: halt wins.
- br_take with br_imm16 = 16'hFFFF: target = pc. Legal one-instruction loop.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Defined:
  - Redirect in RUN latches the target into the pending register, pc <= pc_plus4, state <= SLOT, flush=0.
  - The delay-slot instruction executes; the next non-stalled edge loads the target.
- Undefined:
  - Redirect in RUN loads the target directly into pc, and flush=1 for the following cycle.
  - SLOT is unreachable, slot_err stays 0, and no pending register exists.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC default.
  - State encodings ST_RUN/ST_SLOT/ST_HALT.
  - Target-width constants.
- One natural sub-module: branch_ext16, the combinational shift-by-2 plus sign-extend plus adder producing br_target.
- Sequencing FSM stays in pc_branch_unit.

Test Plan:
- Reset: rst high 1 cycle -> pc=32'h0000_3000, state=00, all flags 0; then 3 idle cycles -> pc=3004, 3008, 300C.
- Backward branch: pc=3010, br_take=1, br_imm16=16'hFFFC -> br_target=3004.
  - With DELAY_SLOT_EN: next pc=3014 (state SLOT), then 3004.
  - Without DELAY_SLOT_EN: next pc=3004 and flush=1 for one cycle.
- Forward branch: pc=3000, br_imm16=16'h0003 -> br_target=3010; pc reaches 3010 as above.
- Jump and jr:
  - pc=3000, jump=1, j_index=26'h0000C10 -> target=3040.
  - jr=1 with jr_addr=32'h0000_3022 -> target=3020, misalign_err=1 and stays 1.
- Stall/halt:
  - stall held 3 cycles during SLOT -> pc and state frozen, then target loads.
  - halt -> state=10, pc frozen for 10 cycles; rst then restores 3000.
- Slot conflict (DELAY_SLOT_EN): br_take in RUN, then jump asserted in SLOT -> jump ignored, original branch target loaded, slot_err=1.
